// File: rtl/cache_pkg.sv
// Shared types and block geometry for the cache miss-fill controller.
package cache_pkg;

  typedef enum logic {
    IDLE,
    FILL
  } fill_state_e;

  localparam int unsigned BLOCK_BYTES     = 16;
  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned OFFSET_BITS     = 4;
  localparam int unsigned WORD_IDX_BITS   = 3;
  localparam int unsigned DATA_W          = 16;
  // One extra bit so a counter can sit at WORDS_PER_BLOCK once the block is covered.
  localparam int unsigned CNT_W           = WORD_IDX_BITS + 1;
  // Nominal memory latency; the controller counts responses and never relies on it.
  localparam int unsigned MEM_LATENCY     = 4;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Pipeline-lookup, main-memory and cache-array signals of one fill controller.
interface cache_fill_fsm_if
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
);

  logic                     miss_detected;
  logic [ADDR_W-1:0]        miss_address;
  logic                     fsm_busy;
  logic                     memory_read;
  logic [ADDR_W-1:0]        memory_address;
  logic                     memory_data_valid;
  logic [DATA_W-1:0]        memory_data;
  logic                     write_data_array;
  logic [WORD_IDX_BITS-1:0] fill_word_idx;
  logic [DATA_W-1:0]        fill_data;
  logic                     write_tag_array;

  modport master (
    input  miss_detected,
    input  miss_address,
    input  memory_data_valid,
    input  memory_data,
    output fsm_busy,
    output memory_read,
    output memory_address,
    output write_data_array,
    output fill_word_idx,
    output fill_data,
    output write_tag_array
  );

  modport slave (
    output miss_detected,
    output miss_address,
    output memory_data_valid,
    output memory_data,
    input  fsm_busy,
    input  memory_read,
    input  memory_address,
    input  write_data_array,
    input  fill_word_idx,
    input  fill_data,
    input  write_tag_array
  );

endinterface

// File: rtl/fill_counter.sv
// Block-word counter: synchronous clear has priority over enable; done flags a full block.
module fill_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == CNT_W'(WORDS_PER_BLOCK));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss controller: stalls the pipeline, issues one read per block word, streams
// the returned words into the data array and writes the tag with the last word.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_fill_fsm_if.master  bus
);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic [CNT_W-1:0]  req_cnt, rsp_cnt;
  logic              req_done, rsp_done;
  logic              cnt_clr, req_en, rsp_en;
  logic              in_fill, last_rsp;

  fill_counter u_req_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (req_en),
    .count (req_cnt),
    .done  (req_done)
  );

  fill_counter u_rsp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (rsp_en),
    .count (rsp_cnt),
    .done  (rsp_done)
  );

  assign in_fill  = (state_q == FILL);
  assign last_rsp = (rsp_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cnt_clr      = 1'b0;
    bus.fsm_busy = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A miss seen while reset is held must not stall the pipeline.
        bus.fsm_busy = bus.miss_detected & rst_n;
        if (bus.miss_detected) begin
          base_d  = {bus.miss_address[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          cnt_clr = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        bus.fsm_busy = 1'b1;
        if (bus.memory_data_valid && last_rsp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request side: one read per cycle from the first FILL cycle until all words are asked for.
  always_comb begin
    req_en             = in_fill & ~req_done;
    bus.memory_read    = req_en;
    bus.memory_address = base_q;
    if (req_en) begin
      bus.memory_address = base_q + ADDR_W'({req_cnt[WORD_IDX_BITS-1:0], 1'b0});
    end
  end

  // Response side: every valid word goes straight to the data array in arrival order.
  always_comb begin
    rsp_en               = in_fill & bus.memory_data_valid & ~rsp_done;
    bus.write_data_array = rsp_en;
    bus.fill_word_idx    = rsp_cnt[WORD_IDX_BITS-1:0];
    bus.fill_data        = bus.memory_data;
    bus.write_tag_array  = rsp_en & last_rsp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  logic [OFFSET_BITS-1:0] unused_offset;
  logic                   unused_req_msb;
  assign unused_offset  = bus.miss_address[OFFSET_BITS-1:0];
  assign unused_req_msb = req_cnt[CNT_W-1];

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a request/response memory model and scoreboard queues.
module tb_cache_fill_fsm;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_fill_fsm_if #(.ADDR_W(16)) bus ();

  cache_fill_fsm #(.ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_addr_q[$];  // request addresses still due
  logic [18:0] exp_wr_q[$];    // {word index, data} writes still due
  logic [15:0] pend_q[$];      // requests seen by memory, not yet answered

  localparam logic [31:0] BasicMask = 32'h0000_1FE0;  // responses in cycles 5..12
  localparam logic [31:0] StallMask = 32'h0001_CE60;  // 5,6,9,10,11,14,15,16

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_block(input logic [15:0] maddr);
    logic [15:0] b;
    b = {maddr[15:4], 4'h0};
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(b + 16'(2 * i));
      exp_wr_q.push_back({3'(i), 16'hA000 + 16'(i)});
    end
  endtask

  // Drive one cycle of inputs, then check everything the DUT shows in that cycle.
  task automatic cycle(input logic miss, input logic [15:0] maddr, input logic valid,
                       input logic exp_busy);
    logic [15:0] a;
    logic [18:0] w;
    a = 16'hFFFF;
    if (valid && pend_q.size() > 0) a = pend_q.pop_front();
    bus.miss_detected     = miss;
    bus.miss_address      = maddr;
    bus.memory_data_valid = valid;
    bus.memory_data       = valid ? (16'hA000 + {13'h0, a[3:1]}) : 16'h0000;
    @(negedge clk);
    chk("fsm_busy", bus.fsm_busy, exp_busy);
    if (bus.memory_read) begin
      if (exp_addr_q.size() == 0) chk("unexpected_read", bus.memory_read, 0);
      else chk("memory_address", bus.memory_address, exp_addr_q.pop_front());
      pend_q.push_back(bus.memory_address);
    end
    if (bus.write_data_array) begin
      if (exp_wr_q.size() == 0) begin
        chk("unexpected_write", bus.write_data_array, 0);
      end else begin
        w = exp_wr_q.pop_front();
        chk("fill_word_idx", bus.fill_word_idx, w[18:16]);
        chk("fill_data", bus.fill_data, w[15:0]);
        chk("write_tag_last", bus.write_tag_array, w[18:16] == 3'd7);
      end
    end else begin
      chk("write_tag_no_data", bus.write_tag_array, 0);
    end
    @(posedge clk);
    #1;
  endtask

  // Miss in cycle 0, held through cycle 'last'; address switches to alt from cycle alt_from.
  task automatic run_fill(input logic [15:0] maddr, input logic [15:0] alt, input int alt_from,
                          input logic [31:0] vmask, input int last);
    push_block(maddr);
    cycle(1'b1, maddr, 1'b0, 1'b1);
    for (int c = 1; c <= last; c++) begin
      cycle(1'b1, (c >= alt_from) ? alt : maddr, vmask[c], 1'b1);
    end
  endtask

  task automatic end_check();
    chk("requests_outstanding", exp_addr_q.size(), 0);
    chk("writes_outstanding", exp_wr_q.size(), 0);
  endtask

  initial begin
    rst_n                 = 1'b0;
    bus.miss_detected     = 1'b1;
    bus.miss_address      = 16'h1236;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = 16'h0000;

    // Reset held two cycles with a miss pending
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", bus.fsm_busy, 0);
    chk("rst_read", bus.memory_read, 0);
    chk("rst_wr_data", bus.write_data_array, 0);
    chk("rst_wr_tag", bus.write_tag_array, 0);
    chk("rst_addr", bus.memory_address, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);

    // Basic fill: tag in cycle 12, busy low in 13
    run_fill(16'h1236, 16'h1236, 99, BasicMask, 12);
    cycle(1'b0, 16'h1236, 1'b0, 1'b0);
    end_check();

    // Memory stalls: tag in cycle 16, busy low in 17
    run_fill(16'h1236, 16'h1236, 99, StallMask, 16);
    cycle(1'b0, 16'h1236, 1'b0, 1'b0);
    end_check();

    // Address change during fill is ignored; back-to-back miss starts in cycle 13
    run_fill(16'h1236, 16'h4000, 3, BasicMask, 12);
    run_fill(16'h4008, 16'h4008, 99, BasicMask, 12);
    cycle(1'b0, 16'h4008, 1'b0, 1'b0);
    end_check();

    // Reset sampled in cycle 6; late responses must not touch the arrays
    push_block(16'h1236);
    cycle(1'b1, 16'h1236, 1'b0, 1'b1);
    for (int c = 1; c <= 5; c++) cycle(1'b1, 16'h1236, BasicMask[c], 1'b1);
    rst_n = 1'b0;
    cycle(1'b1, 16'h1236, 1'b1, 1'b1);
    rst_n = 1'b1;
    exp_addr_q.delete();
    exp_wr_q.delete();
    for (int c = 7; c <= 12; c++) cycle(1'b0, 16'h1236, 1'b1, 1'b0);
    chk("addr_after_reset", bus.memory_address, 0);
    chk("read_after_reset", bus.memory_read, 0);
    pend_q.delete();
    end_check();

    // Block boundary at the top of the address space
    run_fill(16'hFFFE, 16'hFFFE, 99, BasicMask, 12);
    cycle(1'b0, 16'hFFFE, 1'b0, 1'b0);
    chk("boundary_idle_addr", bus.memory_address, 16'hFFF0);
    end_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
